mem_arbiter: RTL

Arbitrates the single-ported RAM between the instruction-fetch path (IF stage) and the data path (MEM stage) of the five-stage MIPS pipeline. It owns the RAM request lines and sequences one access at a time through a small grant FSM. Data requests get priority so the MEM stage drains first, and a bounded streak counter keeps instruction fetch from starving. The per-requester wait signals feed the pipeline stall logic, alongside the forwarding and hazard units.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the data path.
// Data requests win unless instruction fetch has waited STARVE_MAX data grants.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                iREN,
  input  logic [31:0]                         iaddr,
  input  logic                                dREN,
  input  logic                                dWEN,
  input  logic [31:0]                         daddr,
  input  logic [31:0]                         dstore,
  input  logic [31:0]                         ramload,
  input  ramstate_t                           ramstate,
  output logic                                iwait,
  output logic                                dwait,
  output logic [31:0]                         iload,
  output logic [31:0]                         dload,
  output logic                                ramREN,
  output logic                                ramWEN,
  output logic [31:0]                         ramaddr,
  output logic [31:0]                         ramstore,
  output logic                                ramerr,
  output logic [1:0]                          dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]     dbg_streak
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Handshake: a requester raises its REN/WEN and holds address/data stable
  // while its wait is high; the transfer completes in the cycle wait is low.
  arb_state_t      r_state;
  arb_state_t      w_next;
  logic [SW-1:0]   r_streak;
  logic            w_dreq;
  logic            w_icomplete;
  logic            w_dcomplete;

  assign w_dreq      = dREN | dWEN;
  assign w_icomplete = (r_state == IGRANT) && (ramstate == ACCESS);
  assign w_dcomplete = (r_state == DGRANT) && (ramstate == ACCESS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Clear wins over increment so a pending fetch that is finally served resets fairness.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_streak <= '0;
    end else if (!iREN || w_icomplete) begin
      r_streak <= '0;
    end else if (w_dcomplete && (r_streak != STREAK_MAX)) begin
      r_streak <= r_streak + SW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dreq && !(iREN && (r_streak == STREAK_MAX))) begin
          w_next = DGRANT;
        end else if (iREN) begin
          w_next = IGRANT;
        end
      end
      IGRANT: begin
        if (!iREN || (ramstate == ACCESS)) begin
          w_next = IDLE;
        end
      end
      DGRANT: begin
        if (!w_dreq || (ramstate == ACCESS)) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ramerr   = 1'b0;
    case (r_state)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        ramerr  = (ramstate == ERROR);
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramerr   = (ramstate == ERROR);
      end
      default: begin
      end
    endcase
  end

  assign iwait      = iREN & ~w_icomplete;
  assign dwait      = w_dreq & ~w_dcomplete;
  assign iload      = ramload;
  assign dload      = ramload;
  assign dbg_state  = r_state;
  assign dbg_streak = r_streak;

endmodule
